// File: rtl/freq_multi_pkg.sv
// Shared definitions for the multi-channel frequency counter scheduler.
// Optional macro FREQ_SCHED_MASK_EN enables per-channel masking in the sequencer.
package freq_multi_pkg;

  localparam int NF_DEF = 8;   // channels
  localparam int NA_DEF = 3;   // clksel width
  localparam int RW_DEF = 24;  // gate-length counter width
  localparam int SW_DEF = 16;  // sweep counter width
  localparam int ST_MIN = 4;   // minimum settle cycles, matches the counter core pipeline depth

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_GATE   = 2'd2,
    S_STORE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/freq_sched_next_chan.sv
// Circular next-channel finder for the scheduler.
// With FREQ_SCHED_MASK_EN defined it returns the first enabled channel at or after the
// candidate (0 when 'first', else cur+1), wrapping circularly; otherwise a plain +1 mod NF.
// 'wrap' flags that the search passed NF-1; 'any' flags at least one usable channel.
module freq_sched_next_chan
  import freq_multi_pkg::*;
#(
  parameter int NF = NF_DEF,
  parameter int NA = NA_DEF
) (
  input  logic [NA-1:0] cur,
  input  logic          first,
`ifdef FREQ_SCHED_MASK_EN
  input  logic [NF-1:0] chan_en,
`endif
  output logic [NA-1:0] nxt,
  output logic          wrap,
  output logic          any
);

`ifdef FREQ_SCHED_MASK_EN
  // Scan NF positions from the candidate; the first enabled hit wins.
  always_comb begin
    int   base;
    int   idx;
    logic found;
    nxt   = '0;
    wrap  = 1'b0;
    any   = |chan_en;
    found = 1'b0;
    idx   = 0;
    base  = first ? 0 : int'(cur) + 1;
    for (int k = 0; k < NF; k++) begin
      idx = (base + k) % NF;
      if (!found && chan_en[idx]) begin
        found = 1'b1;
        nxt   = NA'(idx);
        wrap  = !first && (idx < base);
      end
    end
  end
`else
  assign any = 1'b1;

  // Sequential order; wrap at NF-1 rather than at 2^NA.
  always_comb begin
    nxt  = '0;
    wrap = 1'b0;
    if (!first) begin
      if (cur == NA'(NF - 1)) wrap = 1'b1;
      else                    nxt  = cur + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/freq_multi_sched.sv
// Control sequencer for the multi-channel frequency counter core (refclk domain).
// Round-robins clksel, gates the accumulator for exactly gate_len cycles per channel and
// strobes ref_carry to store the count. Optional macro FREQ_SCHED_MASK_EN adds chan_en.
module freq_multi_sched
  import freq_multi_pkg::*;
#(
  parameter int NF = NF_DEF,
  parameter int NA = NA_DEF,
  parameter int rw = RW_DEF,
  parameter int ST = ST_MIN,
  parameter int SW = SW_DEF
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          run,
  input  logic          start,
  input  logic [rw-1:0] gate_len,
  input  logic          clr_valid,
`ifdef FREQ_SCHED_MASK_EN
  input  logic [NF-1:0] chan_en,
`endif
  output logic [NA-1:0] clksel,
  output logic          ref_carry,
  output logic          squelch,
  output logic          busy,
  output logic [NF-1:0] valid,
  output logic          sweep_done,
  output logic [SW-1:0] sweep_cnt
);

  sched_state_t  state, state_nx;
  logic [rw-1:0] cnt;
  logic [rw-1:0] g_m1;
  logic [NA-1:0] nxt_ch;
  logic          wrap, any;
  logic          cont;
  logic [NF-1:0] valid_q, set_pend;
  logic          cnt_zero, abort;

  assign cnt_zero = (cnt == '0);
  assign abort    = cont && !run;
  assign valid    = valid_q | set_pend;

  freq_sched_next_chan #(.NF(NF), .NA(NA)) u_next (
    .cur   (clksel),
    .first (state == S_IDLE),
`ifdef FREQ_SCHED_MASK_EN
    .chan_en (chan_en),
`endif
    .nxt   (nxt_ch),
    .wrap  (wrap),
    .any   (any)
  );

  // State register.
  always_ff @(posedge refclk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nx  = state;
    squelch   = 1'b1;
    ref_carry = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if ((run || start) && any) state_nx = S_SETTLE;
      end
      S_SETTLE: begin
        if (abort)         state_nx = S_IDLE;
        else if (cnt_zero) state_nx = S_GATE;
      end
      S_GATE: begin
        squelch = 1'b0;
        if (abort)         state_nx = S_IDLE;
        else if (cnt_zero) state_nx = S_STORE;
      end
      S_STORE: begin
        ref_carry = 1'b1;
        if (!any)              state_nx = S_IDLE;
        else if (wrap && !run) state_nx = S_IDLE;
        else                   state_nx = S_SETTLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Settle/gate down-counter; gate length is latched on every entry to SETTLE.
  always_ff @(posedge refclk) begin
    if (state_nx == S_SETTLE && state != S_SETTLE) begin
      cnt  <= rw'(ST - 1);
      g_m1 <= (gate_len == '0) ? '0 : gate_len - 1'b1;
    end else if (state == S_SETTLE && cnt_zero) begin
      cnt <= g_m1;
    end else if (!cnt_zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Channel select, sweep mode, result flags and sweep status.
  always_ff @(posedge refclk) begin
    if (rst) begin
      clksel     <= '0;
      cont       <= 1'b0;
      set_pend   <= '0;
      valid_q    <= '0;
      sweep_done <= 1'b0;
      sweep_cnt  <= '0;
    end else begin
      set_pend   <= (state == S_STORE) ? (NF'(1) << clksel) : '0;
      valid_q    <= (valid_q & ~{NF{clr_valid}}) | set_pend;
      sweep_done <= (state == S_STORE) && wrap && any;
      if (state == S_STORE && wrap && any) sweep_cnt <= sweep_cnt + 1'b1;
      if (state == S_IDLE && state_nx == S_SETTLE) begin
        clksel <= nxt_ch;
        cont   <= run;
      end
      if (state == S_STORE && any) begin
        clksel <= nxt_ch;
        if (wrap) cont <= run;
      end
    end
  end

endmodule
